// File: rtl/change_dispenser.sv
// Greedy coin-change dispenser: one eject pulse at a time (quarter, dime, nickel) with a settle gap.
// Optional build macro CHANGE_ERR_CHECK_EN rejects amounts that are not a multiple of 5 or exceed MAX_AMOUNT.
module change_dispenser #(
    parameter int AMT_W      = 7,
    parameter int GAP_CYCLES = 2,
    parameter int MAX_AMOUNT = 100
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [AMT_W-1:0] req_amount,
    output logic             nickel_out,
    output logic             dime_out,
    output logic             quarter_out,
    output logic             busy,
    output logic             done,
    output logic             err
);

    // state  | meaning
    // IDLE   | ready for a request; amount latched on handshake
    // SELECT | pick the largest coin that fits, or finish
    // PULSE  | selected coin line high for one cycle
    // GAP    | ejector settle time, GAP_CYCLES cycles
    // DONE   | one-cycle completion pulse
    // ERR    | one-cycle reject pulse (error-check build only)
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SELECT = 3'd1;
    localparam logic [2:0] S_PULSE  = 3'd2;
    localparam logic [2:0] S_GAP    = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;
`ifdef CHANGE_ERR_CHECK_EN
    localparam logic [2:0] S_ERR    = 3'd5;
`endif

    localparam int             GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0]  GAP_LOAD = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;

    localparam logic [AMT_W-1:0] C_QUARTER = AMT_W'(25);
    localparam logic [AMT_W-1:0] C_DIME    = AMT_W'(10);
    localparam logic [AMT_W-1:0] C_NICKEL  = AMT_W'(5);

    if (MAX_AMOUNT < 0 || MAX_AMOUNT >= (1 << AMT_W)) begin : g_max_range
        $error("MAX_AMOUNT does not fit in AMT_W bits");
    end

    logic [2:0]       state;
    logic [AMT_W-1:0] remaining;
    logic [GW-1:0]    gap_cnt;
    logic [2:0]       coin_sel;   // one-hot {quarter, dime, nickel}
    logic             req_bad;

`ifdef CHANGE_ERR_CHECK_EN
    localparam logic [AMT_W:0] MAX_AMT = (AMT_W + 1)'(MAX_AMOUNT);
    always_comb begin
        req_bad = ((req_amount % C_NICKEL) != '0) || ({1'b0, req_amount} > MAX_AMT);
    end
`else
    assign req_bad = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            remaining <= '0;
            gap_cnt   <= '0;
            coin_sel  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
`ifdef CHANGE_ERR_CHECK_EN
                        if (req_bad) begin
                            state <= S_ERR;
                        end else begin
                            remaining <= req_amount;
                            state     <= S_SELECT;
                        end
`else
                        remaining <= req_amount;
                        state     <= S_SELECT;
`endif
                    end
                end
                S_SELECT: begin
                    // compare precedes subtract, so remaining never wraps
                    if (remaining >= C_QUARTER) begin
                        remaining <= remaining - C_QUARTER;
                        coin_sel  <= 3'b100;
                        state     <= S_PULSE;
                    end else if (remaining >= C_DIME) begin
                        remaining <= remaining - C_DIME;
                        coin_sel  <= 3'b010;
                        state     <= S_PULSE;
                    end else if (remaining >= C_NICKEL) begin
                        remaining <= remaining - C_NICKEL;
                        coin_sel  <= 3'b001;
                        state     <= S_PULSE;
                    end else begin
                        state <= S_DONE;
                    end
                end
                S_PULSE: begin
                    if (GAP_CYCLES > 0) begin
                        gap_cnt <= GAP_LOAD;
                        state   <= S_GAP;
                    end else begin
                        state <= S_SELECT;
                    end
                end
                S_GAP: begin
                    if (gap_cnt == '0) begin
                        state <= S_SELECT;
                    end else begin
                        gap_cnt <= gap_cnt - GW'(1);
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // outputs decode from state (plus the latched coin), never from inputs
    assign req_ready   = (state == S_IDLE);
    assign busy        = (state != S_IDLE);
    assign done        = (state == S_DONE);
    assign quarter_out = (state == S_PULSE) && coin_sel[2];
    assign dime_out    = (state == S_PULSE) && coin_sel[1];
    assign nickel_out  = (state == S_PULSE) && coin_sel[0];
`ifdef CHANGE_ERR_CHECK_EN
    assign err         = (state == S_ERR);
`else
    assign err         = 1'b0;
`endif

endmodule
